// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle around the shared memory arbiter: fetch bus, data bus and memory port.
// The arbiter takes the master view because it owns the memory request; the core/memory side takes the slave view.
interface otter_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              ibus_req;
  logic [XLEN-1:0]   ibus_addr;
  logic              ibus_ack;
  logic              ibus_err;
  logic [XLEN-1:0]   ibus_rdata;

  logic              dbus_req;
  logic              dbus_we;
  logic [XLEN/8-1:0] dbus_sel;
  logic [XLEN-1:0]   dbus_addr;
  logic [XLEN-1:0]   dbus_wdata;
  logic              dbus_ack;
  logic              dbus_err;
  logic [XLEN-1:0]   dbus_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_sel;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    input  ibus_req, ibus_addr,
    output ibus_ack, ibus_err, ibus_rdata,
    input  dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
    output dbus_ack, dbus_err, dbus_rdata,
    output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output ibus_req, ibus_addr,
    input  ibus_ack, ibus_err, ibus_rdata,
    output dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
    input  dbus_ack, dbus_err, dbus_rdata,
    input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the Otter ibus and dbus,
// with a watchdog that turns a hung transaction into an error completion.
//
//   state   | meaning
//   IDLE    | no transaction outstanding, arbitrate pending requesters
//   GRANT_I | fetch transaction outstanding on the memory port
//   GRANT_D | load/store transaction outstanding on the memory port
module otter_mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  otter_mem_arbiter_if.master bus,
  output logic                o_busy
);

  localparam int            CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t        state;
  logic          r_last_dbus;
  logic [CW-1:0] wd_cnt;
  logic          i_pend;
  logic          d_pend;
  logic          wd_fire;

  // A requester still acked this cycle is holding req from the finished transfer.
  assign i_pend  = bus.ibus_req & ~bus.ibus_ack;
  assign d_pend  = bus.dbus_req & ~bus.dbus_ack;
  assign wd_fire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      r_last_dbus    <= 1'b0;
      wd_cnt         <= '0;
      bus.ibus_ack   <= 1'b0;
      bus.ibus_err   <= 1'b0;
      bus.ibus_rdata <= '0;
      bus.dbus_ack   <= 1'b0;
      bus.dbus_err   <= 1'b0;
      bus.dbus_rdata <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_sel    <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.ibus_ack <= 1'b0;
      bus.ibus_err <= 1'b0;
      bus.dbus_ack <= 1'b0;
      bus.dbus_err <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (i_pend && (!d_pend || r_last_dbus)) begin
            state         <= GRANT_I;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_sel   <= '1;
            bus.mem_addr  <= bus.ibus_addr;
            bus.mem_wdata <= '0;
          end else if (d_pend) begin
            state         <= GRANT_D;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dbus_we;
            bus.mem_sel   <= bus.dbus_sel;
            bus.mem_addr  <= bus.dbus_addr;
            bus.mem_wdata <= bus.dbus_wdata;
          end
        end
        GRANT_I, GRANT_D: begin
          // A real ack on the watchdog's last cycle still counts as a normal completion.
          if (bus.mem_ack || wd_fire) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            wd_cnt      <= '0;
            r_last_dbus <= (state == GRANT_D);
            if (state == GRANT_I) begin
              bus.ibus_ack   <= 1'b1;
              bus.ibus_err   <= ~bus.mem_ack;
              bus.ibus_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
            end else begin
              bus.dbus_ack   <= 1'b1;
              bus.dbus_err   <= ~bus.mem_ack;
              bus.dbus_rdata <= (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : '0;
            end
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
